// File: rtl/sonic_echo_responder.sv
// Sensor-side responder for the Trig/Echo ultrasonic ranging link: answers a valid trig
// pulse with an echo whose width encodes distance_cm. Optional macro SONIC_JITTER_EN adds LFSR timing noise.
module sonic_echo_responder #(
  parameter int CLK_PER_US = 100,
  parameter int TRIG_MIN_US = 10,
  parameter int BURST_US = 200,
  parameter int US_PER_CM = 58,
  parameter int MAX_CM = 400,
  parameter int TIMEOUT_US = 38000,
  parameter int HOLDOFF_US = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err,
  output logic [15:0] resp_cnt,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG_HI = 3'd1,
    S_DELAY   = 3'd2,
    S_ECHO    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  localparam int MIN_CYC = TRIG_MIN_US * CLK_PER_US;
  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int WW = $clog2(MIN_CYC + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);
  // The rise cycle itself is not counted, so a pin high for N cycles leaves N-1 here.
  localparam logic [WW-1:0] WIDTH_OK = WW'(MIN_CYC - 1);
  localparam logic [23:0] BURST_LAST = 24'(BURST_US - 1);
  localparam logic [23:0] HOLD_LAST = 24'(HOLDOFF_US - 1);
  localparam logic [9:0] MAX_CM_W = 10'(MAX_CM);

  state_t        r_state;
  logic          r_sync1, r_sync2, r_sync_d;
  logic [PW-1:0] r_presc;
  logic [23:0]   r_us_cnt;
  logic [WW-1:0] r_width;
  logic [8:0]    r_dist_q;
  logic [23:0]   r_echo_len;
  logic          r_echo;
  logic          r_trig_err;
  logic [15:0]   r_resp_cnt;
  logic          w_rise, w_fall, w_tick;
  logic [23:0]   w_len;
`ifdef SONIC_JITTER_EN
  logic [15:0]   r_lfsr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= trig;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync_d;
  assign w_fall = ~r_sync2 & r_sync_d;
  assign w_tick = (r_presc == PRESC_LAST);

  always_comb begin
    w_len = 24'(TIMEOUT_US);
    if (r_dist_q != 9'd0 && {1'b0, r_dist_q} <= MAX_CM_W)
      w_len = 24'(r_dist_q) * 24'(US_PER_CM);
`ifdef SONIC_JITTER_EN
    w_len = w_len + 24'(r_lfsr[2:0]);
`endif
  end

  // Every state change clears the prescaler and microsecond counter, so each
  // timed state lasts an exact multiple of CLK_PER_US cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_us_cnt   <= '0;
      r_width    <= '0;
      r_dist_q   <= '0;
      r_echo_len <= '0;
      r_echo     <= 1'b0;
      r_trig_err <= 1'b0;
      r_resp_cnt <= '0;
`ifdef SONIC_JITTER_EN
      r_lfsr     <= 16'hACE1;
`endif
    end else begin
      r_trig_err <= 1'b0;
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      r_us_cnt   <= w_tick ? r_us_cnt + 24'd1 : r_us_cnt;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state  <= S_TRIG_HI;
            r_width  <= '0;
            r_presc  <= '0;
            r_us_cnt <= '0;
          end
        end
        S_TRIG_HI: begin
          if (w_fall) begin
            r_presc  <= '0;
            r_us_cnt <= '0;
            if (r_width >= WIDTH_OK) begin
              r_dist_q <= distance_cm;
              r_state  <= S_DELAY;
`ifdef SONIC_JITTER_EN
              r_lfsr   <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
`endif
            end else begin
              r_trig_err <= 1'b1;
              r_state    <= S_IDLE;
            end
          end else if (r_width < WIDTH_OK) begin
            r_width <= r_width + 1'b1;
          end
        end
        S_DELAY: begin
          if (w_tick && r_us_cnt == BURST_LAST) begin
            r_echo_len <= w_len;
            r_echo     <= 1'b1;
            r_state    <= S_ECHO;
            r_presc    <= '0;
            r_us_cnt   <= '0;
          end
        end
        S_ECHO: begin
          if (w_tick && r_us_cnt == r_echo_len - 24'd1) begin
            r_echo     <= 1'b0;
            r_resp_cnt <= r_resp_cnt + 16'd1;
            r_state    <= S_HOLDOFF;
            r_presc    <= '0;
            r_us_cnt   <= '0;
          end
        end
        S_HOLDOFF: begin
          if (w_tick && r_us_cnt == HOLD_LAST) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_us_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign echo      = r_echo;
  assign busy      = (r_state != S_IDLE);
  assign trig_err  = r_trig_err;
  assign resp_cnt  = r_resp_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Directed bench for sonic_echo_responder, run with scaled-down timing parameters
// so every scenario completes in a few thousand cycles.
module tb_sonic_echo_responder;

  localparam int CLK = 4;
  localparam int TMIN = 10;
  localparam int BURST = 20;
  localparam int UPC = 3;
  localparam int MAXC = 400;
  localparam int TOUT = 1500;
  localparam int HOLD = 50;
`ifdef SONIC_JITTER_EN
  localparam int JMAX = 7 * CLK;
`else
  localparam int JMAX = 0;
`endif
  localparam int LAT = BURST * CLK + 3;
  localparam int HCYC = HOLD * CLK;
  localparam int MINH = TMIN * CLK;
  localparam int W10 = 10 * UPC * CLK;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic [8:0]  distance_cm;
  logic        echo, busy, trig_err;
  logic [15:0] resp_cnt;
  logic [2:0]  dbg_state;

  int n_pass = 0;
  int n_total = 0;
  int n_err_seen = 0;
  int n_echo_rise = 0;
  int exp_resp = 0;

  sonic_echo_responder #(
    .CLK_PER_US(CLK), .TRIG_MIN_US(TMIN), .BURST_US(BURST), .US_PER_CM(UPC),
    .MAX_CM(MAXC), .TIMEOUT_US(TOUT), .HOLDOFF_US(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .distance_cm(distance_cm),
    .echo(echo), .busy(busy), .trig_err(trig_err), .resp_cnt(resp_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (trig_err === 1'b1) n_err_seen++;
  always @(posedge echo) n_echo_rise++;

  task automatic pulse_trig(input int hi);
    @(negedge clk);
    trig = 1'b1;
    repeat (hi) @(negedge clk);
    trig = 1'b0;
  endtask

  // Called right after trig falls: latency to echo rise, echo width, echo-fall to idle.
  task automatic watch(output int lat, output int width, output int hold, output bit to);
    to = 1'b0; lat = 0; width = 0; hold = 0;
    do begin @(posedge clk); #1; lat++; end while (echo !== 1'b1 && lat < 20000);
    if (echo !== 1'b1) begin to = 1'b1; return; end
    width = 1;
    forever begin
      @(posedge clk); #1;
      if (echo !== 1'b1 || width >= 20000) break;
      width++;
    end
    if (echo === 1'b1) begin to = 1'b1; return; end
    while (busy !== 1'b0 && hold < 20000) begin @(posedge clk); #1; hold++; end
    if (busy !== 1'b0) to = 1'b1;
  endtask

  task automatic test_reset;
    n_total++; if (echo !== 1'b0) $display("FAIL reset_echo got %b want 0", echo); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (trig_err !== 1'b0) $display("FAIL reset_trig_err got %b want 0", trig_err); else n_pass++;
    n_total++; if (resp_cnt !== 16'd0) $display("FAIL reset_resp_cnt got %0d want 0", resp_cnt); else n_pass++;
    n_total++; if (dbg_state !== 3'd0) $display("FAIL reset_state got %0d want 0", dbg_state); else n_pass++;
  endtask

  task automatic test_basic;
    int lat, w, h; bit to;
    distance_cm = 9'd10;
    pulse_trig(MINH);
    watch(lat, w, h, to);
    exp_resp++;
    n_total++; if (to) $display("FAIL basic_timeout got timeout want completion"); else n_pass++;
    n_total++; if (lat !== LAT) $display("FAIL basic_latency got %0d want %0d", lat, LAT); else n_pass++;
    n_total++; if (w < W10 || w > W10 + JMAX || w % CLK != 0)
      $display("FAIL basic_width got %0d want %0d(+jitter)", w, W10); else n_pass++;
    n_total++; if (h !== HCYC) $display("FAIL basic_holdoff got %0d want %0d", h, HCYC); else n_pass++;
    n_total++; if (resp_cnt !== 16'(exp_resp)) $display("FAIL basic_resp_cnt got %0d want %0d", resp_cnt, exp_resp); else n_pass++;
  endtask

  task automatic test_short_trig;
    int e0, r0;
    e0 = n_err_seen; r0 = n_echo_rise;
    distance_cm = 9'd10;
    pulse_trig(MINH - 1);
    repeat (LAT + 200) @(negedge clk);
    n_total++; if (n_err_seen - e0 !== 1) $display("FAIL short_trig_err_pulses got %0d want 1", n_err_seen - e0); else n_pass++;
    n_total++; if (n_echo_rise !== r0) $display("FAIL short_echo_rises got %0d want 0", n_echo_rise - r0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL short_busy got %b want 0", busy); else n_pass++;
    n_total++; if (resp_cnt !== 16'(exp_resp)) $display("FAIL short_resp_cnt got %0d want %0d", resp_cnt, exp_resp); else n_pass++;
  endtask

  task automatic test_distance;
    int dv[5] = '{0, 401, 400, 1, 511};
    int ew[5] = '{TOUT*CLK, TOUT*CLK, 400*UPC*CLK, UPC*CLK, TOUT*CLK};
    int lat, w, h; bit to;
    for (int i = 0; i < 5; i++) begin
      distance_cm = 9'(dv[i]);
      pulse_trig(MINH + 10);
      watch(lat, w, h, to);
      exp_resp++;
      n_total++; if (to || w < ew[i] || w > ew[i] + JMAX || w % CLK != 0)
        $display("FAIL dist_%0d_width got %0d (timeout=%0d) want %0d", dv[i], w, to, ew[i]); else n_pass++;
    end
    n_total++; if (resp_cnt !== 16'(exp_resp)) $display("FAIL dist_resp_cnt got %0d want %0d", resp_cnt, exp_resp); else n_pass++;
  endtask

  task automatic test_ignore;
    int lat, w, h, e0, r0; bit to;
    e0 = n_err_seen; r0 = n_echo_rise;
    distance_cm = 9'd10;
    pulse_trig(MINH);
    fork
      watch(lat, w, h, to);
      begin
        repeat (100) @(negedge clk);
        pulse_trig(50);
        repeat (80) @(negedge clk);
        pulse_trig(50);
      end
    join
    exp_resp++;
    repeat (LAT + 200) @(negedge clk);
    n_total++; if (to || w < W10 || w > W10 + JMAX) $display("FAIL ignore_width got %0d want %0d", w, W10); else n_pass++;
    n_total++; if (n_echo_rise - r0 !== 1) $display("FAIL ignore_echo_rises got %0d want 1", n_echo_rise - r0); else n_pass++;
    n_total++; if (n_err_seen !== e0) $display("FAIL ignore_trig_err got %0d want 0", n_err_seen - e0); else n_pass++;
    n_total++; if (resp_cnt !== 16'(exp_resp)) $display("FAIL ignore_resp_cnt got %0d want %0d", resp_cnt, exp_resp); else n_pass++;
  endtask

  task automatic test_dist_change;
    int lat, w, h; bit to;
    distance_cm = 9'd10;
    pulse_trig(MINH);
    fork
      watch(lat, w, h, to);
      begin repeat (20) @(negedge clk); distance_cm = 9'd50; end
    join
    exp_resp++;
    n_total++; if (to || w < W10 || w > W10 + JMAX) $display("FAIL dist_change_width got %0d want %0d", w, W10); else n_pass++;
  endtask

  task automatic test_held_trig;
    int lat, w, h, e0, r0; bit to;
    distance_cm = 9'd10;
    pulse_trig(MINH);
    fork
      watch(lat, w, h, to);
      begin repeat (300) @(negedge clk); trig = 1'b1; end
    join
    exp_resp++;
    e0 = n_err_seen; r0 = n_echo_rise;
    repeat (200) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL held_busy got %b want 0", busy); else n_pass++;
    trig = 1'b0;
    repeat (20) @(negedge clk);
    n_total++; if (n_err_seen !== e0 || n_echo_rise !== r0 || busy !== 1'b0)
      $display("FAIL held_no_start got err=%0d rise=%0d busy=%b want 0 0 0", n_err_seen - e0, n_echo_rise - r0, busy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int w[8]; int lat, h; bit to; bit all_eq;
    distance_cm = 9'd10;
    for (int i = 0; i < 8; i++) begin
      pulse_trig(MINH);
      watch(lat, w[i], h, to);
      exp_resp++;
      n_total++; if (to || w[i] < W10 || w[i] > W10 + JMAX || w[i] % CLK != 0)
        $display("FAIL b2b_%0d_width got %0d want %0d..%0d", i, w[i], W10, W10 + JMAX); else n_pass++;
    end
    all_eq = 1'b1;
    for (int i = 1; i < 8; i++) if (w[i] != w[0]) all_eq = 1'b0;
`ifdef SONIC_JITTER_EN
    n_total++; if (all_eq) $display("FAIL b2b_jitter got all widths %0d want variation", w[0]); else n_pass++;
`endif
    n_total++; if (resp_cnt !== 16'(exp_resp)) $display("FAIL b2b_resp_cnt got %0d want %0d", resp_cnt, exp_resp); else n_pass++;
  endtask

  task automatic test_reset_mid_echo;
    int lat, w, h, n; bit to;
    distance_cm = 9'd10;
    pulse_trig(MINH);
    n = 0;
    while (echo !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    n_total++; if (echo !== 1'b1) $display("FAIL rst_mid_echo_rise got %b want 1", echo); else n_pass++;
    repeat (40) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_total++; if (echo !== 1'b0) $display("FAIL rst_mid_echo got %b want 0", echo); else n_pass++;
    n_total++; if (busy !== 1'b0 || resp_cnt !== 16'd0)
      $display("FAIL rst_mid_state got busy=%b cnt=%0d want 0 0", busy, resp_cnt); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    exp_resp = 0;
    pulse_trig(MINH);
    watch(lat, w, h, to);
    exp_resp++;
    n_total++; if (to || lat !== LAT || w < W10 || w > W10 + JMAX)
      $display("FAIL rst_after got lat=%0d width=%0d want %0d %0d", lat, w, LAT, W10); else n_pass++;
    n_total++; if (resp_cnt !== 16'(exp_resp)) $display("FAIL rst_after_resp_cnt got %0d want %0d", resp_cnt, exp_resp); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    trig = 1'b0;
    distance_cm = 9'd0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_basic;
    test_short_trig;
    test_distance;
    test_ignore;
    test_dist_change;
    test_held_trig;
    test_back_to_back;
    test_reset_mid_echo;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
